// File: rtl/ff_rr_arbiter_if.sv
// ff_rr_arbiter_if
// Bundles the requester-side and register-side signals of the round-robin
// flag-register arbiter.
//
// Handshake: a requester holds req[i] high for as long as it wants the shared
// bit. gnt[i] (registered) tells it that it owns the register. Every clock edge
// on which req[i] && gnt[i] is a transfer: d_in[i] is loaded into q, and
// q_valid/q_owner report it on the following cycle. Dropping req[i] while
// granted ends the grant without a transfer.
//
// Signals:
//   req       [NUM_REQ]  per-requester level request
//   d_in      [NUM_REQ]  per-requester data bit (sampled only for the owner)
//   gnt       [NUM_REQ]  registered one-hot grant, zero when idle
//   q                    shared registered data bit
//   q_valid              one-cycle strobe after each capture
//   q_owner   [ID_W]     requester index of the bit held in q
//   busy                 |gnt
//   state_dbg            arbiter FSM state (0 = IDLE, 1 = GRANT)
interface ff_rr_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] d_in;
  logic [NUM_REQ-1:0] gnt;
  logic               q;
  logic               q_valid;
  logic [ID_W-1:0]    q_owner;
  logic               busy;
  logic               state_dbg;

  // Requester side.
  modport master (
    output req, d_in,
    input  gnt, q, q_valid, q_owner, busy, state_dbg
  );

  // Arbiter side.
  modport slave (
    input  req, d_in,
    output gnt, q, q_valid, q_owner, busy, state_dbg
  );
endinterface

// File: rtl/ff_rr_arbiter.sv
// ff_rr_arbiter
// Round-robin arbiter in front of a single async-clear D flip-flop. The
// winning requester keeps the grant for up to HOLD_CYCLES captures; each
// capture loads its d_in bit into q and tags it with the owner index.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset, clears all state
//   bus    ff_rr_arbiter_if.slave: req, d_in in; gnt, q, q_valid, q_owner,
//          busy, state_dbg out
module ff_rr_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic           clk,
  input  logic           reset,
  ff_rr_arbiter_if.slave bus
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int SW    = ID_W + 1;
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             state_q, state_n;
  logic [NUM_REQ-1:0] gnt_q, gnt_n;
  logic [ID_W-1:0]    own_q, own_n;
  logic [ID_W-1:0]    ptr_q, ptr_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic               q_q, q_n;
  logic               qv_q, qv_n;
  logic [ID_W-1:0]    qo_q, qo_n;

  // Arbitration helpers.
  logic               own_req;
  logic               capture;
  logic               release_g;
  logic [ID_W-1:0]    ptr_rel;
  logic [ID_W-1:0]    arb_ptr;
  logic               found;
  logic [ID_W-1:0]    win;
  logic [SW-1:0]      sum;
  logic [ID_W-1:0]    cand;

  assign own_req   = bus.req[own_q];
  assign capture   = (state_q == GRANT) && own_req;
  // The grant ends when the owner drops its request or takes its last capture.
  assign release_g = (state_q == GRANT) && (!own_req || (cnt_q == CNT_W'(1)));
  assign ptr_rel   = (own_q == ID_W'(NUM_REQ - 1)) ? '0 : own_q + ID_W'(1);
  // On a release the next winner is searched from the already-advanced
  // pointer, so a handover costs no idle cycle.
  assign arb_ptr   = release_g ? ptr_rel : ptr_q;

  // First set request at or above arb_ptr, wrapping around. The sum cannot
  // exceed 2*NUM_REQ-2, so one conditional subtract performs the modulo.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, arb_ptr} + SW'(k);
      if (sum >= SW'(NUM_REQ)) begin
        sum = sum - SW'(NUM_REQ);
      end
      cand = sum[ID_W-1:0];
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    state_n = found ? GRANT : IDLE;
      GRANT:   state_n = (release_g && !found) ? IDLE : GRANT;
      default: state_n = IDLE;
    endcase
  end

  // FSM output / datapath next values.
  always_comb begin
    gnt_n = gnt_q;
    own_n = own_q;
    cnt_n = cnt_q;
    ptr_n = ptr_q;
    q_n   = q_q;
    qo_n  = qo_q;
    qv_n  = 1'b0;

    if (capture) begin
      q_n   = bus.d_in[own_q];
      qo_n  = own_q;
      qv_n  = 1'b1;
      cnt_n = cnt_q - CNT_W'(1);
    end

    if (release_g) begin
      ptr_n = ptr_rel;
      if (!found) begin
        gnt_n = '0;
      end
    end

    if (((state_q == IDLE) || release_g) && found) begin
      gnt_n      = '0;
      gnt_n[win] = 1'b1;
      own_n      = win;
      cnt_n      = CNT_W'(HOLD_CYCLES);
    end
  end

  // Datapath registers, including the shared flag flip-flop q.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt_q <= '0;
      own_q <= '0;
      cnt_q <= '0;
      ptr_q <= '0;
      q_q   <= 1'b0;
      qv_q  <= 1'b0;
      qo_q  <= '0;
    end else begin
      gnt_q <= gnt_n;
      own_q <= own_n;
      cnt_q <= cnt_n;
      ptr_q <= ptr_n;
      q_q   <= q_n;
      qv_q  <= qv_n;
      qo_q  <= qo_n;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.q         = q_q;
  assign bus.q_valid   = qv_q;
  assign bus.q_owner   = qo_q;
  assign bus.busy      = |gnt_q;
  assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_ff_rr_arbiter.sv
// tb_ff_rr_arbiter
// Drives identical stimulus into two arbiters (HOLD_CYCLES=2 and 1) and
// compares both against a cycle-level reference model of the grant rules.
module tb_ff_rr_arbiter;
  localparam int N = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ff_rr_arbiter_if #(.NUM_REQ(N)) bus0 ();
  ff_rr_arbiter_if #(.NUM_REQ(N)) bus1 ();

  ff_rr_arbiter #(.NUM_REQ(N), .HOLD_CYCLES(2)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  ff_rr_arbiter #(.NUM_REQ(N), .HOLD_CYCLES(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  // ---------------- scoreboard state ----------------
  int  vectors     = 0;
  int  miscompares = 0;
  bit  done        = 1'b0;

  // Per-cycle expectation: {gnt0, q_valid0, gnt1, q_valid1}
  logic [9:0] cyc_q[$];
  // Capture expectation: {instance, owner[1:0], q}
  logic [3:0] exp_q[$];

  // Reference model: owner (-1 = nobody), captures left, rotation pointer.
  int m_owner[2];
  int m_rem[2];
  int m_ptr[2];
  int m_hold[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic bitof(input logic [N-1:0] v, input int i);
    logic [N-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  // First requester at or after p, wrapping around; -1 if none.
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (bitof(r, (p + k) % N)) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = -1;
      m_rem[k]   = 0;
      m_ptr[k]   = 0;
    end
    m_hold[0] = 2;
    m_hold[1] = 1;
  endtask

  // ---------------- driver ----------------
  // Apply inputs for the coming rising edge and record what that edge must do.
  task automatic apply(input logic [N-1:0] r, input logic [N-1:0] d);
    logic [N-1:0] g[2];
    logic         qv[2];
    int           o;
    int           w;
    bit           rel;
    bus0.req  = r;
    bus0.d_in = d;
    bus1.req  = r;
    bus1.d_in = d;
    for (int k = 0; k < 2; k++) begin
      qv[k] = 1'b0;
      if (m_owner[k] < 0) begin
        w = pick(r, m_ptr[k]);
        if (w >= 0) begin
          m_owner[k] = w;
          m_rem[k]   = m_hold[k];
        end
      end else begin
        o   = m_owner[k];
        rel = 1'b1;
        if (bitof(r, o)) begin
          qv[k] = 1'b1;
          exp_q.push_back({1'(k), 2'(o), bitof(d, o)});
          m_rem[k]--;
          rel = (m_rem[k] == 0);
        end
        if (rel) begin
          m_ptr[k]   = (o + 1) % N;
          w          = pick(r, m_ptr[k]);
          m_owner[k] = w;
          if (w >= 0) m_rem[k] = m_hold[k];
        end
      end
      g[k] = (m_owner[k] < 0) ? '0 : (N'(1) << m_owner[k]);
    end
    cyc_q.push_back({g[0], qv[0], g[1], qv[1]});
  endtask

  task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] d);
    @(negedge clk);
    apply(r, d);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_gnt0"},   bus0.gnt,     0);
    check({tag, "_q0"},     bus0.q,       0);
    check({tag, "_qv0"},    bus0.q_valid, 0);
    check({tag, "_qown0"},  bus0.q_owner, 0);
    check({tag, "_busy0"},  bus0.busy,    0);
    check({tag, "_gnt1"},   bus1.gnt,     0);
    check({tag, "_q1"},     bus1.q,       0);
    check({tag, "_qv1"},    bus1.q_valid, 0);
    check({tag, "_busy1"},  bus1.busy,    0);
  endtask

  // Asserts reset between clock edges, checks the asynchronous clear,
  // then releases on the next falling edge with no requests pending.
  task automatic reset_now(input string tag);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 check_cleared(tag);
    cyc_q.delete();
    exp_q.delete();
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    apply('0, '0);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [N-1:0] prev[2];
    bit           prev_ok;
    logic [9:0]   c;
    logic [3:0]   e;
    prev_ok = 1'b0;
    prev[0] = '0;
    prev[1] = '0;
    while (!done) begin
      @(posedge clk);
      #1;
      if (done) break;
      if (!reset) begin
        prev_ok = 1'b0;
        continue;
      end
      if (cyc_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL cycle_expectation: got none expected one at %0t", $time);
      end else begin
        c = cyc_q.pop_front();
        check("gnt0", bus0.gnt,     c[9:6]);
        check("qv0",  bus0.q_valid, c[5]);
        check("gnt1", bus1.gnt,     c[4:1]);
        check("qv1",  bus1.q_valid, c[0]);
      end
      if (bus0.q_valid) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL cap0: got unexpected strobe expected none at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("cap0", {1'b0, bus0.q_owner, bus0.q}, e);
        end
      end
      if (bus1.q_valid) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL cap1: got unexpected strobe expected none at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("cap1", {1'b1, bus1.q_owner, bus1.q}, e);
        end
      end
      check("onehot0_0", $onehot0(bus0.gnt), 1);
      check("onehot0_1", $onehot0(bus1.gnt), 1);
      check("busy0", bus0.busy, |bus0.gnt);
      check("busy1", bus1.busy, |bus1.gnt);
      if (prev_ok && bus0.q_valid) check("qv_prev_gnt0", prev[0][bus0.q_owner], 1);
      if (prev_ok && bus1.q_valid) check("qv_prev_gnt1", prev[1][bus1.q_owner], 1);
      prev[0] = bus0.gnt;
      prev[1] = bus1.gnt;
      prev_ok = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [N-1:0] r;
    logic [N-1:0] d;
    bus0.req  = '0;
    bus0.d_in = '0;
    bus1.req  = '0;
    bus1.d_in = '0;
    model_reset();
    #2 reset = 1'b0;
    #1 check_cleared("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    apply('0, '0);

    // Single requester holds for HOLD_CYCLES captures, then idle.
    repeat (4) cyc(4'b0100, 4'b0100);
    repeat (2) cyc(4'b0000, 4'b0000);

    // All requesting: rotation 0,1,2,3,0 with q pattern from d_in.
    reset_now("rst_a");
    repeat (11) cyc(4'b1111, 4'b1010);

    // Owner 0 drops on its first grant cycle; grant hands to 1.
    reset_now("rst_b");
    cyc(4'b0011, 4'b0011);
    cyc(4'b0010, 4'b0011);
    repeat (3) cyc(4'b0010, 4'b0010);
    cyc(4'b0000, 4'b0000);

    // Pointer wrap from requester 3 back to 0.
    reset_now("rst_c");
    repeat (2) cyc(4'b1000, 4'b1000);
    repeat (6) cyc(4'b1001, 4'b1001);
    cyc(4'b0000, 4'b0000);

    // Reset in the middle of a grant while q=1 and q_valid=1.
    reset_now("rst_d");
    repeat (2) cyc(4'b0100, 4'b0100);
    reset_now("rst_mid");
    repeat (4) cyc(4'b1010, 4'b1010);

    // Two requesters held: the HOLD_CYCLES=1 arbiter alternates every cycle.
    reset_now("rst_e");
    repeat (8) cyc(4'b0110, 4'b0110);

    // Randomized traffic with request persistence, plus one reset.
    r = '0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r = N'($urandom_range(0, 15));
      d = N'($urandom_range(0, 15));
      if (i == 200) reset_now("rst_rand");
      cyc(r, d);
    end
    cyc(4'b0000, 4'b0000);

    @(posedge clk);
    #3 done = 1'b1;
    check("cyc_q_drained", cyc_q.size(), 0);
    check("exp_q_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
